matched_filter_sequencer: RTL and testbench
===========================================

Name: matched_filter_sequencer

Overview:
Sequences one matched_filter instance across NUM_FINGERPRINTS stored fingerprints. On start, it captures CAPTURE_LENGTH samples into an internal buffer. It then replays the buffer to the filter once per fingerprint and collects each match score. Finally it reports the best-scoring fingerprint index and a threshold detection flag. It sits between the sample stream and the matched filter.

Parameters:
SAMPLE_DATA_WIDTH, 8, sample width in bits
MATCH_SCORE_WIDTH, 16, filter score width in bits (unsigned)
CAPTURE_LENGTH, 1000, samples per capture and per replay
NUM_FINGERPRINTS, 4, fingerprints to test (>=2)
TIMEOUT_CYCLES, 4000000, maximum wait for a score after the last replayed sample

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a run; ignored while busy
threshold  in  MATCH_SCORE_WIDTH  detection threshold; latched on an accepted start
sample_valid  in  1  input sample strobe
sample_data  in  SAMPLE_DATA_WIDTH  input sample
mf_rst  out  1  reset to the matched filter
mf_sel  out  $clog2(NUM_FINGERPRINTS)  fingerprint select to the filter
mf_axiov  out  1  replay sample valid
mf_axiod  out  SAMPLE_DATA_WIDTH  replay sample
mf_score_valid  in  1  filter score strobe
mf_score  in  MATCH_SCORE_WIDTH  filter score
busy  out  1  high from an accepted start until the REPORT cycle (inclusive)
result_valid  out  1  one-cycle pulse, run complete
result_index  out  $clog2(NUM_FINGERPRINTS)  index of the best fingerprint
result_score  out  MATCH_SCORE_WIDTH  best score
detected  out  1  result_score >= latched threshold
timeout_err  out  1  sticky; at least one fingerprint timed out this run

Behaviour:
- Reset values:
  - all outputs 0 except mf_rst, which is 1 while rst is high.
  - state=IDLE; counters, best registers and capture buffer write pointer cleared.
  - Reset mid-run aborts immediately; no result_valid is produced.
- States: IDLE -> CAPTURE -> ARM -> REPLAY -> WAIT_SCORE -> (ARM with next fp | REPORT) -> IDLE.
- IDLE:
  - start accepted: latch threshold; clear best_score=0, best_idx=0, timeout_err=0, fp=0; busy=1; go to CAPTURE.
  - result_* and detected hold their previous values until the next accepted start, then clear to 0.
- CAPTURE:
  - Write sample_data to buffer[wr_ptr] on each sample_valid cycle; gaps allowed.
  - After the CAPTURE_LENGTH-th accepted sample, go to ARM. Samples arriving outside CAPTURE are dropped.
- ARM:
  - Exactly one cycle with mf_rst=1; mf_sel=fp.
  - mf_sel changes only in ARM and is stable through REPLAY and WAIT_SCORE.
- REPLAY:
  - Buffer read latency is 1 cycle; mf_axiod/mf_axiov are registered.
  - mf_axiov is high for exactly CAPTURE_LENGTH contiguous cycles, beginning 2 cycles after entering REPLAY.
  - Samples replay in capture order, addresses 0..CAPTURE_LENGTH-1.
  - Go to WAIT_SCORE on the cycle after the last beat. mf_axiov=0 outside replay beats.
- WAIT_SCORE:
  - Timeout counter starts at 0 on entry.
  - mf_score_valid: candidate=mf_score.
  - Counter reaches TIMEOUT_CYCLES without a score: candidate=0; timeout_err=1.
  - Update best only if candidate > best_score (strict). Ties keep the lower index; an all-zero run reports index 0.
  - If fp==NUM_FINGERPRINTS-1, go to REPORT; else fp++ and go to ARM.
  - mf_score_valid in any other state is ignored.
- REPORT:
  - One cycle: result_valid=1; result_index=best_idx; result_score=best_score; detected=(best_score >= threshold_latched), unsigned compare. Then IDLE.
  - A new start is accepted earliest the cycle after REPORT; start in REPORT is ignored.
- Simultaneous events:
  - start and rst together: rst wins.
  - Score on the same cycle the timeout is reached: the score wins and timeout_err is not set.
- Capture buffer is not cleared between runs; each run fully overwrites it.

Test Plan:
Bench parameters: CAPTURE_LENGTH=8, NUM_FINGERPRINTS=4, TIMEOUT_CYCLES=16; filter model returns a scripted score 3 cycles after the last beat.
1. start, threshold=100; capture samples 1..8 contiguous; scores 40,120,90,120 -> 4 replays of 1..8 with 8 contiguous mf_axiov beats each; mf_sel 0,1,2,3; 4 mf_rst pulses; result_index=1, result_score=120, detected=1, one result_valid pulse.
2. Capture with sample_valid toggled every other cycle -> replay order still 1..8 and contiguous; capture phase takes 16 cycles.
3. Scores 10,20,30,40 with threshold=40 -> index 3, detected=1; rerun with threshold=41 -> detected=0.
4. No score for fp 2; others 5,7,–,6 -> fp 2 times out after 16 cycles; timeout_err=1; result_index=1, score=7; next run with all scores present -> timeout_err=0.
5. start pulsed during REPLAY; samples driven during REPLAY -> both ignored; buffer contents unchanged; exactly one result_valid.
6. rst asserted mid-REPLAY of fp 1 -> next cycle all outputs 0 except mf_rst=1; no result_valid; a following start runs normally from fp 0.

Source files
------------

// File: rtl/matched_filter_sequencer.sv
// Runs one matched filter over a captured sample block once per stored fingerprint
// and reports the best-scoring fingerprint together with a threshold detection flag.
module matched_filter_sequencer #(
  parameter int unsigned SAMPLE_DATA_WIDTH = 8,
  parameter int unsigned MATCH_SCORE_WIDTH = 16,
  parameter int unsigned CAPTURE_LENGTH    = 1000,
  parameter int unsigned NUM_FINGERPRINTS  = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 4000000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [MATCH_SCORE_WIDTH-1:0]        threshold,
  input  logic                                sample_valid,
  input  logic [SAMPLE_DATA_WIDTH-1:0]        sample_data,
  output logic                                mf_rst,
  output logic [$clog2(NUM_FINGERPRINTS)-1:0] mf_sel,
  output logic                                mf_axiov,
  output logic [SAMPLE_DATA_WIDTH-1:0]        mf_axiod,
  input  logic                                mf_score_valid,
  input  logic [MATCH_SCORE_WIDTH-1:0]        mf_score,
  output logic                                busy,
  output logic                                result_valid,
  output logic [$clog2(NUM_FINGERPRINTS)-1:0] result_index,
  output logic [MATCH_SCORE_WIDTH-1:0]        result_score,
  output logic                                detected,
  output logic                                timeout_err
);

  localparam int unsigned SEL_W = $clog2(NUM_FINGERPRINTS);
  localparam int unsigned PTR_W = $clog2(CAPTURE_LENGTH);
  localparam int unsigned CNT_W = $clog2(CAPTURE_LENGTH + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_ARM, S_REPLAY, S_WAIT_SCORE, S_REPORT
  } state_t;

  state_t                       r_state;
  logic [SAMPLE_DATA_WIDTH-1:0] r_mem [CAPTURE_LENGTH];
  logic [SAMPLE_DATA_WIDTH-1:0] r_rd_data;
  logic                         r_rd_v;
  logic [PTR_W-1:0]             r_wr_ptr;
  logic [CNT_W-1:0]             r_rd_ptr;
  logic [SEL_W-1:0]             r_fp;
  logic [TO_W-1:0]              r_to_cnt;
  logic [MATCH_SCORE_WIDTH-1:0] r_thresh;
  logic [MATCH_SCORE_WIDTH-1:0] r_best_score;
  logic [SEL_W-1:0]             r_best_idx;

  logic                         r_mf_rst;
  logic [SEL_W-1:0]             r_mf_sel;
  logic                         r_mf_axiov;
  logic [SAMPLE_DATA_WIDTH-1:0] r_mf_axiod;
  logic                         r_busy;
  logic                         r_result_valid;
  logic [SEL_W-1:0]             r_result_index;
  logic [MATCH_SCORE_WIDTH-1:0] r_result_score;
  logic                         r_detected;
  logic                         r_timeout_err;

  logic                         w_wr_en;
  logic                         w_rd_en;
  logic                         w_timeout;
  logic                         w_event;
  logic                         w_take;
  logic [MATCH_SCORE_WIDTH-1:0] w_cand;
  logic [MATCH_SCORE_WIDTH-1:0] w_best_score;
  logic [SEL_W-1:0]             w_best_idx;

  assign w_wr_en      = (r_state == S_CAPTURE) && sample_valid;
  assign w_rd_en      = (r_state == S_REPLAY) && (r_rd_ptr < CNT_W'(CAPTURE_LENGTH));
  // A score arriving on the timeout cycle takes priority over the timeout
  assign w_timeout    = (r_state == S_WAIT_SCORE) && !mf_score_valid &&
                        (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_event      = (r_state == S_WAIT_SCORE) && (mf_score_valid || w_timeout);
  assign w_cand       = mf_score_valid ? mf_score : '0;
  assign w_take       = w_event && (w_cand > r_best_score);
  assign w_best_score = w_take ? w_cand : r_best_score;
  assign w_best_idx   = w_take ? r_fp : r_best_idx;

  // Capture buffer: write port fed by the sample stream, one-cycle registered read port
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= sample_data;
    if (w_rd_en) r_rd_data <= r_mem[r_rd_ptr[PTR_W-1:0]];
  end

  // Sequencer state, counters, best tracking and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_rd_v         <= 1'b0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_fp           <= '0;
      r_to_cnt       <= '0;
      r_thresh       <= '0;
      r_best_score   <= '0;
      r_best_idx     <= '0;
      r_mf_rst       <= 1'b1;
      r_mf_sel       <= '0;
      r_mf_axiov     <= 1'b0;
      r_mf_axiod     <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_index <= '0;
      r_result_score <= '0;
      r_detected     <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_mf_rst       <= 1'b0;
      r_result_valid <= 1'b0;
      r_rd_v         <= w_rd_en;
      r_mf_axiov     <= r_rd_v;
      if (r_rd_v) r_mf_axiod <= r_rd_data;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_thresh       <= threshold;
            r_best_score   <= '0;
            r_best_idx     <= '0;
            r_timeout_err  <= 1'b0;
            r_fp           <= '0;
            r_wr_ptr       <= '0;
            r_busy         <= 1'b1;
            r_result_index <= '0;
            r_result_score <= '0;
            r_detected     <= 1'b0;
            r_state        <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (sample_valid) begin
            if (r_wr_ptr == PTR_W'(CAPTURE_LENGTH - 1)) begin
              r_wr_ptr <= '0;
              r_mf_rst <= 1'b1;
              r_mf_sel <= r_fp;
              r_state  <= S_ARM;
            end else begin
              r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
          end
        end
        S_ARM: begin
          r_rd_ptr <= '0;
          r_state  <= S_REPLAY;
        end
        S_REPLAY: begin
          if (w_rd_en) r_rd_ptr <= r_rd_ptr + CNT_W'(1);
          // Last beat is on the output and nothing is left in the read pipe
          if (r_mf_axiov && !r_rd_v) begin
            r_to_cnt <= '0;
            r_state  <= S_WAIT_SCORE;
          end
        end
        S_WAIT_SCORE: begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
          if (w_event) begin
            r_best_score <= w_best_score;
            r_best_idx   <= w_best_idx;
            if (w_timeout) r_timeout_err <= 1'b1;
            if (r_fp == SEL_W'(NUM_FINGERPRINTS - 1)) begin
              r_result_valid <= 1'b1;
              r_result_index <= w_best_idx;
              r_result_score <= w_best_score;
              r_detected     <= (w_best_score >= r_thresh);
              r_state        <= S_REPORT;
            end else begin
              r_fp     <= r_fp + SEL_W'(1);
              r_mf_sel <= r_fp + SEL_W'(1);
              r_mf_rst <= 1'b1;
              r_state  <= S_ARM;
            end
          end
        end
        S_REPORT: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mf_rst       = r_mf_rst;
  assign mf_sel       = r_mf_sel;
  assign mf_axiov     = r_mf_axiov;
  assign mf_axiod     = r_mf_axiod;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign result_index = r_result_index;
  assign result_score = r_result_score;
  assign detected     = r_detected;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_matched_filter_sequencer.sv
// Randomized bench for matched_filter_sequencer with a scripted filter and a
// fingerprint-level reference model of the expected result.
module tb_matched_filter_sequencer;

  localparam int unsigned SDW  = 8;
  localparam int unsigned MSW  = 16;
  localparam int unsigned L    = 8;
  localparam int unsigned NFP  = 4;
  localparam int unsigned TO   = 16;
  localparam int unsigned SELW = $clog2(NFP);

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [MSW-1:0]  threshold;
  logic            sample_valid;
  logic [SDW-1:0]  sample_data;
  logic            mf_rst;
  logic [SELW-1:0] mf_sel;
  logic            mf_axiov;
  logic [SDW-1:0]  mf_axiod;
  logic            mf_score_valid;
  logic [MSW-1:0]  mf_score;
  logic            busy;
  logic            result_valid;
  logic [SELW-1:0] result_index;
  logic [MSW-1:0]  result_score;
  logic            detected;
  logic            timeout_err;

  matched_filter_sequencer #(
    .SAMPLE_DATA_WIDTH(SDW), .MATCH_SCORE_WIDTH(MSW), .CAPTURE_LENGTH(L),
    .NUM_FINGERPRINTS(NFP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .mf_rst(mf_rst), .mf_sel(mf_sel), .mf_axiov(mf_axiov), .mf_axiod(mf_axiod),
    .mf_score_valid(mf_score_valid), .mf_score(mf_score),
    .busy(busy), .result_valid(result_valid), .result_index(result_index),
    .result_score(result_score), .detected(detected), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int score_q [NFP];          // scripted score per fingerprint, -1 = filter never answers
  logic [SDW-1:0] exp_buf [L];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int fp_of(input int n);
    if (n < 1) return 0;
    if (n > NFP) return NFP - 1;
    return n - 1;
  endfunction

  // One full run: start, capture, replays with scripted scores, report.
  task automatic run_once(input int thr, input bit seq, input bit gaps,
                          input bit disturb, input bit abort);
    int k, cap_cycles, n_arm, beat_cnt, arm_cyc, prev_beat_cyc, last_beat_cyc;
    int score_cyc, rv_cnt, rv_cyc, total_beats, j, rv_seen, ax_seen;
    bit done, abort_now;
    int exp_idx, exp_score;
    bit exp_to, exp_det;

    // Reference: best = strictly greater wins, missing scores count as 0
    exp_idx = 0; exp_score = 0; exp_to = 0;
    for (int f = 0; f < NFP; f++) begin
      int cand;
      cand = (score_q[f] < 0) ? 0 : score_q[f];
      if (score_q[f] < 0) exp_to = 1;
      if (cand > exp_score) begin exp_score = cand; exp_idx = f; end
    end
    exp_det = (exp_score >= thr);
    for (int i = 0; i < L; i++) exp_buf[i] = seq ? SDW'(i + 1) : SDW'($urandom);

    cap_cycles = gaps ? 2 * L : L;
    k = 0; n_arm = 0; beat_cnt = 0; arm_cyc = -100; prev_beat_cyc = -100;
    last_beat_cyc = -100; score_cyc = -1; rv_cnt = 0; rv_cyc = -1; total_beats = 0;
    done = 0; abort_now = 0;

    while (!done) begin
      @(posedge clk); #1;
      if (k == 1) begin
        chk("busy_after_start", busy, 1);
        chk("result_cleared_on_start", result_score, 0);
        chk("timeout_err_cleared_on_start", timeout_err, 0);
      end
      if (mf_rst) begin
        if (n_arm == 0) chk("capture_cycles", k, 1 + cap_cycles);
        else begin
          chk("beats_per_replay", beat_cnt, L);
          chk("arm_gap", k - last_beat_cyc, (score_q[fp_of(n_arm)] < 0) ? TO + 1 : 4);
        end
        chk("mf_sel_at_arm", mf_sel, n_arm);
        n_arm++; arm_cyc = k; beat_cnt = 0;
      end
      if (mf_axiov) begin
        if (beat_cnt == 0) chk("first_beat_latency", k - arm_cyc, 3);
        else chk("beat_contiguous", k - prev_beat_cyc, 1);
        if (beat_cnt < L) chk("replay_data", mf_axiod, exp_buf[beat_cnt]);
        else chk("beat_overrun", beat_cnt, L - 1);
        chk("mf_sel_stable", mf_sel, fp_of(n_arm));
        prev_beat_cyc = k; beat_cnt++; total_beats++;
        if (beat_cnt == L) begin
          last_beat_cyc = k;
          if (score_q[fp_of(n_arm)] >= 0) score_cyc = k + 3;
        end
        if (abort && n_arm == 2 && beat_cnt == 3) abort_now = 1;
      end
      if (result_valid) begin
        rv_cnt++; rv_cyc = k;
        chk("beats_last_replay", beat_cnt, L);
        chk("result_index", result_index, exp_idx);
        chk("result_score", result_score, exp_score);
        chk("detected", detected, exp_det);
        chk("timeout_err", timeout_err, exp_to);
        chk("busy_in_report", busy, 1);
      end
      if (rv_cyc >= 0 && k == rv_cyc + 1) chk("busy_after_report", busy, 0);
      if (rv_cyc >= 0 && k == rv_cyc + 4) begin
        chk("result_hold", result_score, exp_score);
        done = 1;
      end
      if (k >= 2000) begin
        chk("run_done_in_budget", done, 1);
        done = 1;
      end

      // Drive inputs for cycle k
      start = (k == 0);
      threshold = (k == 0) ? MSW'(thr) : MSW'($urandom);
      if (disturb && mf_axiov && n_arm == 2 && beat_cnt == 5) start = 1;
      if (disturb && result_valid) start = 1;
      j = k - 1;
      if (j >= 0 && j < cap_cycles) begin
        if (gaps) begin
          sample_valid = (j % 2 == 1);
          sample_data  = sample_valid ? exp_buf[j / 2] : SDW'($urandom);
        end else begin
          sample_valid = 1'b1;
          sample_data  = exp_buf[j];
        end
      end else begin
        sample_valid = disturb ? 1'($urandom) : 1'b0;
        sample_data  = SDW'($urandom);
      end
      mf_score_valid = (k == score_cyc);
      mf_score = mf_score_valid ? MSW'(score_q[fp_of(n_arm)]) : MSW'($urandom);
      if (disturb && mf_axiov && !mf_score_valid) begin
        mf_score_valid = 1'($urandom);
        mf_score       = MSW'($urandom);
      end
      if (abort_now) begin rst = 1'b1; done = 1; end
      k++;
    end

    start = 0; sample_valid = 0; mf_score_valid = 0;

    if (!abort) begin
      chk("arm_count", n_arm, NFP);
      chk("result_pulses", rv_cnt, 1);
      chk("total_beats", total_beats, NFP * L);
    end else begin
      @(posedge clk); #1;
      chk("abort_mf_rst", mf_rst, 1);
      chk("abort_mf_sel", mf_sel, 0);
      chk("abort_mf_axiov", mf_axiov, 0);
      chk("abort_mf_axiod", mf_axiod, 0);
      chk("abort_busy", busy, 0);
      chk("abort_result_valid", result_valid, 0);
      chk("abort_result_score", result_score, 0);
      chk("abort_timeout_err", timeout_err, 0);
      rst = 0;
      rv_seen = 0; ax_seen = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (result_valid) rv_seen++;
        if (mf_axiov) ax_seen++;
      end
      chk("abort_no_result", rv_seen, 0);
      chk("abort_no_replay", ax_seen, 0);
      chk("abort_mf_rst_released", mf_rst, 0);
    end
  endtask

  initial begin
    rst = 1; start = 0; threshold = '0; sample_valid = 0; sample_data = '0;
    mf_score_valid = 0; mf_score = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mf_rst", mf_rst, 1);
    chk("reset_busy", busy, 0);
    chk("reset_result_valid", result_valid, 0);
    chk("reset_mf_axiov", mf_axiov, 0);
    chk("reset_mf_sel", mf_sel, 0);
    chk("reset_result_score", result_score, 0);
    chk("reset_detected", detected, 0);
    chk("reset_timeout_err", timeout_err, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("mf_rst_released", mf_rst, 0);

    score_q = '{40, 120, 90, 120};   run_once(100, 1, 0, 0, 0);
    score_q = '{3, 9, 1, 2};         run_once(5, 0, 1, 0, 0);
    score_q = '{10, 20, 30, 40};     run_once(40, 0, 0, 0, 0);
    score_q = '{10, 20, 30, 40};     run_once(41, 0, 0, 0, 0);
    score_q = '{5, 7, -1, 6};        run_once(3, 0, 0, 0, 0);
    score_q = '{5, 7, 8, 6};         run_once(3, 0, 0, 0, 0);
    score_q = '{11, 4, 11, 2};       run_once(12, 0, 0, 1, 0);
    score_q = '{1, 2, 3, 4};         run_once(1, 0, 0, 0, 1);
    score_q = '{0, 0, 0, 0};         run_once(0, 0, 0, 0, 0);
    score_q = '{-1, -1, -1, -1};     run_once(1, 0, 1, 0, 0);

    for (int r = 0; r < 6; r++) begin
      for (int f = 0; f < NFP; f++)
        score_q[f] = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 7));
      run_once(int'($urandom_range(0, 8)), 0, 1'($urandom), 1'($urandom), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
